// File: rtl/mem_arb_pkg.sv
// Shared types and store-size encoding for the unified memory port arbiter.
// The size codes match the memory_access stage's store encoding.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam logic [1:0] MEM_NONE = 2'h0;
  localparam logic [1:0] MEM_B    = 2'h1;
  localparam logic [1:0] MEM_H    = 2'h2;
  localparam logic [1:0] MEM_W    = 2'h3;

  function automatic logic is_store(input logic [1:0] wr);
    return wr != MEM_NONE;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// One transaction in flight; data wins unless fetch has been starved MAX_DATA_STREAK times.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic [1:0]        d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic [1:0]        mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  state_t              r_state;
  owner_t              r_owner;
  logic [STREAK_W-1:0] r_streak;
  logic                r_mem_req;
  logic [1:0]          r_mem_wr;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic w_any_req;
  logic w_pick_d;
  logic w_resp;

  assign w_any_req = if_req | d_req;
  // Data is the older instruction, so it wins unless fetch has waited out a full streak.
  assign w_pick_d  = d_req & ~(if_req & (r_streak == STREAK_MAX));
  assign w_resp    = (r_state == RESP) & mem_rvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= OWN_IF;
      r_streak    <= '0;
      r_mem_req   <= 1'b0;
      r_mem_wr    <= MEM_NONE;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state   <= REQ;
            r_mem_req <= 1'b1;
            if (w_pick_d) begin
              r_owner     <= OWN_D;
              r_mem_addr  <= d_addr;
              r_mem_wr    <= d_wr;
              r_mem_wdata <= d_wdata;
            end else begin
              r_owner     <= OWN_IF;
              r_mem_addr  <= if_addr;
              r_mem_wr    <= MEM_NONE;
              r_mem_wdata <= '0;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            r_mem_req <= 1'b0;
            r_state   <= is_store(r_mem_wr) ? IDLE : RESP;
          end
        end
        RESP: begin
          if (mem_rvalid) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // Streak only counts data wins that actually delayed a waiting fetch.
      if (!if_req) begin
        r_streak <= '0;
      end else if (r_state == IDLE && w_any_req) begin
        if (!w_pick_d)
          r_streak <= '0;
        else if (r_streak != STREAK_MAX)
          r_streak <= r_streak + STREAK_W'(1);
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  assign if_gnt    = r_mem_req & mem_gnt & (r_owner == OWN_IF);
  assign d_gnt     = r_mem_req & mem_gnt & (r_owner == OWN_D);
  assign if_rvalid = w_resp & (r_owner == OWN_IF);
  assign d_rvalid  = w_resp & (r_owner == OWN_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic [1:0]    d_wr = 2'd0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic [1:0]    mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gq[$];
  int last_drv_cyc = -100;
  int last_ig_cyc = -100;
  int n_dgnt = 0;
  bit auto_mem = 1'b0;
  bit hold = 1'b0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction model: one pending transfer, awaiting either acceptance or read data.
  logic          m_busy = 1'b0, m_wait = 1'b0, m_fetch = 1'b1;
  logic [AW-1:0] m_addr = '0;
  logic [1:0]    m_wr = '0;
  logic [DW-1:0] m_wdata = '0;
  int            m_streak = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_busy <= 1'b0; m_wait <= 1'b0; m_fetch <= 1'b1; m_streak <= 0;
      m_addr <= '0; m_wr <= '0; m_wdata <= '0;
    end else if (!m_busy) begin
      if (if_req || d_req) begin
        m_busy <= 1'b1;
        m_wait <= 1'b0;
        if (d_req && !(if_req && m_streak == MAXS)) begin
          m_fetch <= 1'b0; m_addr <= d_addr; m_wr <= d_wr; m_wdata <= d_wdata;
          m_streak <= if_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
        end else begin
          m_fetch <= 1'b1; m_addr <= if_addr; m_wr <= 2'd0;
          m_streak <= 0;
        end
      end else begin
        m_streak <= 0;
      end
    end else begin
      if (!if_req) m_streak <= 0;
      if (!m_wait && mem_gnt) begin
        if (m_wr != 2'd0) m_busy <= 1'b0;
        else m_wait <= 1'b1;
      end else if (m_wait && mem_rvalid) begin
        m_busy <= 1'b0;
        m_wait <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic exp_req;
    exp_req = m_busy && !m_wait;
    chk("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
    if (exp_req) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wr", {30'd0, mem_wr}, {30'd0, m_wr});
      if (m_wr != 2'd0) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("if_gnt", {31'd0, if_gnt}, {31'd0, exp_req && mem_gnt && m_fetch});
    chk("d_gnt", {31'd0, d_gnt}, {31'd0, exp_req && mem_gnt && !m_fetch});
    chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, m_busy && m_wait && mem_rvalid && m_fetch});
    chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, m_busy && m_wait && mem_rvalid && !m_fetch});
    if (if_rvalid) chk("if_rdata", if_rdata, mem_rdata);
    if (d_rvalid) chk("d_rdata", d_rdata, mem_rdata);
    if (if_gnt) begin gq.push_back(0); last_ig_cyc = cyc; end
    if (d_gnt) begin gq.push_back(1); n_dgnt++; end
    if (d_rvalid) last_drv_cyc = cyc;
  end

  // Advance one cycle; acts as requesters (drop or renew after gnt) and, optionally, a zero-wait memory.
  task automatic step();
    logic pr, ig, dg;
    #1;
    pr = mem_req && mem_gnt && (mem_wr == 2'd0);
    ig = if_gnt;
    dg = d_gnt;
    @(posedge clk);
    #2;
    if (auto_mem) begin
      mem_gnt    = mem_req;
      mem_rvalid = pr;
      mem_rdata  = $urandom;
    end
    if (ig) begin if_addr = if_addr + 32'd4; if_req = hold; end
    if (dg) begin d_addr = d_addr + 32'd4; d_wdata = $urandom; d_req = hold; end
  endtask

  task automatic run_until_grants(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (gq.size() < n && k < budget) begin step(); k++; end
    chk({name, "_budget"}, {31'd0, gq.size() >= n}, 32'd1);
  endtask

  initial begin
    int exp4[6];
    exp4 = '{1, 1, 1, 1, 0, 1};

    // Reset
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wr", {30'd0, mem_wr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);

    // 1: single fetch, zero-wait memory driven by hand
    if_req = 1'b1; if_addr = 32'h100;
    step();
    mem_gnt = 1'b1;
    #1;
    chk("t1_mem_req", {31'd0, mem_req}, 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_mem_wr", {30'd0, mem_wr}, 32'd0);
    chk("t1_if_gnt", {31'd0, if_gnt}, 32'd1);
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("t1_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("t1_if_rdata", if_rdata, 32'hDEADBEEF);
    chk("t1_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    step();
    mem_rvalid = 1'b0;
    step();

    // 2: word store with three wait cycles; requester input changes are ignored
    n_dgnt = 0;
    d_req = 1'b1; d_wr = 2'd3; d_addr = 32'h200; d_wdata = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) mem_gnt = 1'b1;
      if (i == 1) begin d_addr = 32'h999; d_wdata = 32'h0; end
      #1;
      chk("t2_mem_req", {31'd0, mem_req}, 32'd1);
      chk("t2_mem_addr", mem_addr, 32'h200);
      chk("t2_mem_wdata", mem_wdata, 32'h12345678);
      chk("t2_mem_wr", {30'd0, mem_wr}, 32'd3);
    end
    step();
    mem_gnt = 1'b0;
    #1;
    chk("t2_idle_mem_req", {31'd0, mem_req}, 32'd0);
    step(); step();
    chk("t2_one_dgnt", n_dgnt, 32'd1);

    // 3: simultaneous fetch and load; data first, fetch issued two cycles after d_rvalid
    auto_mem = 1'b1;
    gq.delete();
    if_req = 1'b1; if_addr = 32'h500;
    d_req = 1'b1; d_wr = 2'd0; d_addr = 32'h600;
    run_until_grants(2, 20, "t3");
    for (int i = 0; i < 4; i++) step();
    if (gq.size() >= 2) begin
      chk("t3_first_data", gq[0], 32'd1);
      chk("t3_then_fetch", gq[1], 32'd0);
    end
    chk("t3_fetch_after_drv", last_ig_cyc - last_drv_cyc, 32'd2);

    // 4: both held continuously; fetch gets in after MAXS data grants
    gq.delete();
    hold = 1'b1;
    if_req = 1'b1; if_addr = 32'h1000;
    d_req = 1'b1; d_wr = 2'd0; d_addr = 32'h2000;
    run_until_grants(6, 60, "t4");
    for (int i = 0; i < 6; i++)
      if (i < gq.size()) chk($sformatf("t4_order%0d", i), gq[i], exp4[i]);
    hold = 1'b0;
    for (int i = 0; i < 20; i++) step();
    auto_mem = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    step();

    // 5: reset while waiting for read data drops the response
    if_req = 1'b1; if_addr = 32'h300;
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
    #1;
    chk("t5_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t5_mem_addr", mem_addr, 32'd0);
    chk("t5_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("t5_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    step();
    mem_rvalid = 1'b0;
    #1;
    chk("t5_still_idle", {31'd0, mem_req}, 32'd0);

    // 6: stray mem_rvalid in IDLE and stray mem_gnt in RESP
    mem_rvalid = 1'b1;
    #1;
    chk("t6_no_rvalid", {31'd0, if_rvalid | d_rvalid}, 32'd0);
    step();
    mem_rvalid = 1'b0; d_req = 1'b1; d_wr = 2'd0; d_addr = 32'h400;
    #1;
    chk("t6_idle_kept", {31'd0, mem_req}, 32'd0);
    step();
    mem_gnt = 1'b1;
    step();
    #1;
    chk("t6_resp_no_gnt", {31'd0, d_gnt | if_gnt}, 32'd0);
    chk("t6_resp_no_req", {31'd0, mem_req}, 32'd0);
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    #1;
    chk("t6_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("t6_d_rdata", d_rdata, 32'hCAFEF00D);
    step();
    mem_rvalid = 1'b0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
